// File: rtl/coo_adj_aggregate_if.sv
// coo_adj_aggregate_if: memory and result bus of the COO aggregation stage.
// start              - begin an aggregation run
// coo_address/in     - COO edge memory port, data {node a, node b} one cycle after address
// fm_wm_row_address/in - FM_WM row memory port, data one cycle after address
// fm_wm_adj_row_out  - FEATURE_ROWS x WEIGHT_COLS result matrix
// done_comb          - result complete and stable
// coo_error          - out-of-range node index seen in the current run
// master modport: the aggregation stage; slave modport: memories and consumer.
interface coo_adj_aggregate_if #(
    parameter int FEATURE_ROWS    = 6,
    parameter int WEIGHT_COLS     = 3,
    parameter int DOT_PROD_WIDTH  = 16,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int COO_BW          = $clog2(FEATURE_ROWS),
    parameter int COO_ADDR_WIDTH  = $clog2(COO_NUM_OF_COLS)
) ();
    logic                                                     start;
    logic [COO_ADDR_WIDTH-1:0]                                coo_address;
    logic [2*COO_BW-1:0]                                      coo_in;
    logic [COO_BW-1:0]                                        fm_wm_row_address;
    logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]               fm_wm_row_in;
    logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_adj_row_out;
    logic                                                     done_comb;
    logic                                                     coo_error;
    modport master (
        input  start, coo_in, fm_wm_row_in,
        output coo_address, fm_wm_row_address, fm_wm_adj_row_out, done_comb, coo_error
    );
    modport slave (
        output start, coo_in, fm_wm_row_in,
        input  coo_address, fm_wm_row_address, fm_wm_adj_row_out, done_comb, coo_error
    );
endinterface

// File: rtl/coo_adj_aggregate.sv
// coo_adj_aggregate: computes ADJ x (FM x WM) from a COO edge list and FM_WM rows.
// Ports: clk, reset (sync, active-low), bus (coo_adj_aggregate_if.master).
// Each edge takes 4 cycles: request edge, latch {a,b} and request row b,
// add row b into out[a] and request row a, add row a into out[b] (skipped for a==b).
// Edges with an index >= FEATURE_ROWS contribute nothing and set coo_error.
// Optional macro COO_SELF_LOOP_EN: append a 2-cycle-per-row pass adding row i
// into out[i], giving (ADJ+I) x FM_WM.
module coo_adj_aggregate #(
    parameter int FEATURE_ROWS    = 6,
    parameter int WEIGHT_COLS     = 3,
    parameter int DOT_PROD_WIDTH  = 16,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int COO_BW          = $clog2(FEATURE_ROWS),
    parameter int COO_ADDR_WIDTH  = $clog2(COO_NUM_OF_COLS)
) (
    input logic                  clk,
    input logic                  reset,
    coo_adj_aggregate_if.master  bus
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CLEAR    = 4'd1;
    localparam logic [3:0] S_EDGE_REQ = 4'd2;
    localparam logic [3:0] S_EDGE_LAT = 4'd3;
    localparam logic [3:0] S_ROW_A    = 4'd4;
    localparam logic [3:0] S_ROW_B    = 4'd5;
    localparam logic [3:0] S_DONE     = 4'd6;
    localparam logic [3:0] S_SELF_REQ = 4'd7;
    localparam logic [3:0] S_SELF_ACC = 4'd8;
    localparam logic [COO_ADDR_WIDTH-1:0] LAST_EDGE = COO_ADDR_WIDTH'(COO_NUM_OF_COLS - 1);
    localparam logic [COO_BW:0] ROWS = (COO_BW + 1)'(FEATURE_ROWS);

    logic [3:0]                                               state;
    logic [COO_ADDR_WIDTH-1:0]                                k;
    logic [COO_BW-1:0]                                        a, b, in_a, in_b, row_addr_q;
    logic                                                     bad;
    logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] mat;
    logic                                                     done, err;
    logic [COO_ADDR_WIDTH-1:0]                                coo_addr;
`ifdef COO_SELF_LOOP_EN
    logic [COO_BW-1:0]                                        i;
`endif

    assign in_a = bus.coo_in[COO_BW +: COO_BW];
    assign in_b = bus.coo_in[0 +: COO_BW];
    assign bus.fm_wm_adj_row_out = mat;
    assign bus.done_comb         = done;
    assign bus.coo_error         = err;
    assign bus.coo_address       = coo_addr;

    // Row b is requested straight from coo_in in EDGE_LAT so its data lands in ROW_A;
    // outside the request states the last address is held.
`ifdef COO_SELF_LOOP_EN
    assign bus.fm_wm_row_address = state == S_EDGE_LAT ? in_b :
                                   state == S_ROW_A    ? a    :
                                   state == S_SELF_REQ ? i    : row_addr_q;
`else
    assign bus.fm_wm_row_address = state == S_EDGE_LAT ? in_b :
                                   state == S_ROW_A    ? a    : row_addr_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            k          <= '0;
            a          <= '0;
            b          <= '0;
            bad        <= 1'b0;
            row_addr_q <= '0;
            coo_addr   <= '0;
            mat        <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef COO_SELF_LOOP_EN
            i          <= '0;
`endif
        end else begin
            row_addr_q <= bus.fm_wm_row_address;
            case (state)
                S_IDLE: state <= bus.start ? S_CLEAR : S_IDLE;
                S_CLEAR: begin
                    mat      <= '0;
                    err      <= 1'b0;
                    k        <= '0;
                    coo_addr <= '0;
                    state    <= S_EDGE_REQ;
                end
                S_EDGE_REQ: state <= S_EDGE_LAT;
                S_EDGE_LAT: begin
                    a     <= in_a;
                    b     <= in_b;
                    bad   <= ({1'b0, in_a} >= ROWS) || ({1'b0, in_b} >= ROWS);
                    state <= S_ROW_A;
                end
                S_ROW_A: begin
                    if (bad)
                        err <= 1'b1;
                    else
                        for (int j = 0; j < WEIGHT_COLS; j++)
                            mat[a][j] <= mat[a][j] + bus.fm_wm_row_in[j];
                    state <= S_ROW_B;
                end
                S_ROW_B: begin
                    if (!bad && a != b)
                        for (int j = 0; j < WEIGHT_COLS; j++)
                            mat[b][j] <= mat[b][j] + bus.fm_wm_row_in[j];
                    if (k == LAST_EDGE) begin
`ifdef COO_SELF_LOOP_EN
                        i     <= '0;
                        state <= S_SELF_REQ;
`else
                        state <= S_DONE;
`endif
                    end else begin
                        k        <= k + 1'b1;
                        coo_addr <= k + 1'b1;
                        state    <= S_EDGE_REQ;
                    end
                end
`ifdef COO_SELF_LOOP_EN
                S_SELF_REQ: state <= S_SELF_ACC;
                S_SELF_ACC: begin
                    for (int j = 0; j < WEIGHT_COLS; j++)
                        mat[i][j] <= mat[i][j] + bus.fm_wm_row_in[j];
                    i     <= i + 1'b1;
                    state <= i == COO_BW'(FEATURE_ROWS - 1) ? S_DONE : S_SELF_REQ;
                end
`endif
                // done_comb rises one cycle after entering DONE and drops as soon as start is taken.
                S_DONE: begin
                    done  <= !bus.start;
                    state <= bus.start ? S_CLEAR : S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coo_adj_aggregate.sv
// tb_coo_adj_aggregate: table vectors, hand sequences and random runs against a matrix model.
module tb_coo_adj_aggregate;
`ifdef COO_SELF_LOOP_EN
    localparam int LAT = 38;
`else
    localparam int LAT = 26;
`endif
    typedef logic [15:0] mat_t [6][3];
    typedef struct {
        logic [5:0] e [6];
        mat_t       m;
        bit         err;
        bit         wrap;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [5:0]  coo [8];
    logic [15:0] fm [8][3];
    int vec_cnt = 0;
    int miss_cnt = 0;
    vec_t tbl [5];
    mat_t cur;

    coo_adj_aggregate_if bus ();
    coo_adj_aggregate dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.coo_in       <= coo[bus.coo_address];
        bus.fm_wm_row_in <= {fm[bus.fm_wm_row_address][2], fm[bus.fm_wm_row_address][1], fm[bus.fm_wm_row_address][0]};
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_mat(input string tag, input mat_t m, input bit er);
        for (int r = 0; r < 6; r++)
            chk($sformatf("%s row%0d", tag, r), 64'(bus.fm_wm_adj_row_out[r]), 64'({m[r][2], m[r][1], m[r][0]}));
        chk({tag, " coo_error"}, 64'(bus.coo_error), 64'(er));
    endtask

    task automatic set_fm_default();
        for (int r = 0; r < 8; r++) begin
            fm[r][0] = 16'(r + 1);
            fm[r][1] = 16'(10 * (r + 1));
            fm[r][2] = 16'(100 * (r + 1));
        end
    endtask

    task automatic add_identity(inout mat_t m);
`ifdef COO_SELF_LOOP_EN
        for (int r = 0; r < 6; r++)
            for (int j = 0; j < 3; j++)
                m[r][j] = m[r][j] + fm[r][j];
`endif
    endtask

    // Undirected adjacency product: every valid edge adds each endpoint's row into the other.
    task automatic model(output mat_t m, output bit er);
        int a, b;
        er = 1'b0;
        for (int r = 0; r < 6; r++)
            for (int j = 0; j < 3; j++)
                m[r][j] = 16'd0;
        for (int k = 0; k < 6; k++) begin
            a = int'(coo[k][5:3]);
            b = int'(coo[k][2:0]);
            if (a >= 6 || b >= 6) er = 1'b1;
            else
                for (int j = 0; j < 3; j++) begin
                    m[a][j] = m[a][j] + fm[b][j];
                    if (a != b) m[b][j] = m[b][j] + fm[a][j];
                end
        end
        add_identity(m);
    endtask

    // Called with clk low; returns just after the edge where done_comb is first seen high.
    task automatic run(input string tag);
        int lat;
        lat = -1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, " done_drop"}, 64'(bus.done_comb), 64'd0);
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.done_comb) begin
                lat = n;
                break;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'(LAT));
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        coo[6] = 6'o13;
        coo[7] = 6'o24;
        set_fm_default();
        tbl[0].e = '{6'o01, 6'o22, 6'o22, 6'o22, 6'o22, 6'o22};
        tbl[0].m = '{'{2, 20, 200}, '{1, 10, 100}, '{15, 150, 1500}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
        tbl[0].err = 0; tbl[0].wrap = 0;
        tbl[1].e = '{6'o70, 6'o01, 6'o12, 6'o23, 6'o34, 6'o45};
        tbl[1].m = '{'{2, 20, 200}, '{4, 40, 400}, '{6, 60, 600}, '{8, 80, 800}, '{10, 100, 1000}, '{5, 50, 500}};
        tbl[1].err = 1; tbl[1].wrap = 0;
        tbl[2].e = '{6'o01, 6'o01, 6'o33, 6'o33, 6'o33, 6'o33};
        tbl[2].m = '{'{16'hFFFE, 16'hFFFE, 16'hFFFE}, '{2, 20, 200}, '{0, 0, 0}, '{16, 160, 1600}, '{0, 0, 0}, '{0, 0, 0}};
        tbl[2].err = 0; tbl[2].wrap = 1;
        tbl[3].e = '{6'o50, 6'o50, 6'o50, 6'o50, 6'o50, 6'o50};
        tbl[3].m = '{'{36, 360, 3600}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{6, 60, 600}};
        tbl[3].err = 0; tbl[3].wrap = 0;
        tbl[4].e = '{6'o06, 6'o66, 6'o77, 6'o11, 6'o36, 6'o24};
        tbl[4].m = '{'{0, 0, 0}, '{2, 20, 200}, '{5, 50, 500}, '{0, 0, 0}, '{3, 30, 300}, '{0, 0, 0}};
        tbl[4].err = 1; tbl[4].wrap = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 6; r++)
            for (int j = 0; j < 3; j++)
                cur[r][j] = 16'd0;
        check_mat("reset", cur, 1'b0);
        chk("reset done_comb", 64'(bus.done_comb), 64'd0);
        chk("reset coo_address", 64'(bus.coo_address), 64'd0);
        chk("reset fm_wm_row_address", 64'(bus.fm_wm_row_address), 64'd0);

        for (int v = 0; v < 5; v++) begin
            set_fm_default();
            if (tbl[v].wrap)
                for (int j = 0; j < 3; j++) fm[1][j] = 16'hFFFF;
            for (int k = 0; k < 6; k++) coo[k] = tbl[v].e[k];
            cur = tbl[v].m;
            add_identity(cur);
            run($sformatf("vec%0d", v));
            check_mat($sformatf("vec%0d", v), cur, tbl[v].err);
        end

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold done_comb", 64'(bus.done_comb), 64'd1);
            check_mat($sformatf("hold%0d", c), cur, tbl[4].err);
        end

        set_fm_default();
        for (int k = 0; k < 6; k++) coo[k] = tbl[0].e[k];
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int r = 0; r < 6; r++)
            for (int j = 0; j < 3; j++)
                cur[r][j] = 16'd0;
        check_mat("abort", cur, 1'b0);
        chk("abort done_comb", 64'(bus.done_comb), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cur = tbl[0].m;
        add_identity(cur);
        run("after_abort");
        check_mat("after_abort", cur, 1'b0);

        for (int t = 0; t < 20; t++) begin
            bit er;
            for (int k = 0; k < 6; k++)
                coo[k] = {3'($urandom_range(0, 6)), 3'($urandom_range(0, 6))};
            for (int r = 0; r < 8; r++)
                for (int j = 0; j < 3; j++)
                    fm[r][j] = (t % 2) ? 16'($urandom) : 16'($urandom_range(0, 99));
            model(cur, er);
            run($sformatf("rand%0d", t));
            check_mat($sformatf("rand%0d", t), cur, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/coo_adj_aggregate.md
Name: coo_adj_aggregate

Overview:
- Aggregation stage of the GCN datapath: computes ADJ x (FM x WM) using the COO edge list and the precomputed FM_WM product rows.
- Produces the full FEATURE_ROWS x WEIGHT_COLS result matrix and raises done_comb.
- Feeds the argmax stage directly. That stage samples the matrix over FEATURE_ROWS consecutive cycles while done_comb is high.
- Reads both source memories through address/data ports with registered (1-cycle) read latency.

Parameters:
- FEATURE_ROWS, 6, number of graph nodes (rows of FM_WM and of the result).
- WEIGHT_COLS, 3, columns of FM_WM and of the result.
- DOT_PROD_WIDTH, 16, width of each FM_WM and result element.
- COO_NUM_OF_COLS, 6, number of edges in the COO list.
- COO_BW, $clog2(FEATURE_ROWS), width of a node index.
- COO_ADDR_WIDTH, $clog2(COO_NUM_OF_COLS), width of the edge address.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin aggregation; sampled only in IDLE or DONE.
- coo_address  out  COO_ADDR_WIDTH  edge index requested from COO memory.
- coo_in  in  2 x COO_BW  {node a, node b}; valid 1 cycle after coo_address.
- fm_wm_row_address  out  COO_BW  FM_WM row requested.
- fm_wm_row_in  in  WEIGHT_COLS x DOT_PROD_WIDTH  FM_WM row; valid 1 cycle after address.
- fm_wm_adj_row_out  out  FEATURE_ROWS x WEIGHT_COLS x DOT_PROD_WIDTH  result matrix.
- done_comb  out  1  result complete and stable.
- coo_error  out  1  sticky flag: an out-of-range node index was seen in the current run.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: matrix, done_comb, coo_error, coo_address, fm_wm_row_address.
  - Reset mid-run aborts immediately; no partial result is kept.
- States: IDLE, CLEAR, EDGE_REQ, EDGE_LAT, ROW_A, ROW_B, DONE.
- IDLE:
  - start=1 -> CLEAR.
- CLEAR (1 cycle):
  - Zero the matrix, clear coo_error, set edge counter k=0.
- Edge processing, 4 cycles per edge, no overlap between edges:
  - EDGE_REQ: drive coo_address=k.
  - EDGE_LAT: latch a and b from coo_in; drive fm_wm_row_address=b.
  - ROW_A: out[a] += fm_wm_row_in (this is row b); drive fm_wm_row_address=a.
  - ROW_B: if a!=b, out[b] += fm_wm_row_in (this is row a). Then, if k==COO_NUM_OF_COLS-1 -> DONE; else k++ and -> EDGE_REQ.
- Self-edge (a==b): row a is added to out[a] exactly once.
- Out-of-range index (a or b >= FEATURE_ROWS):
  - The edge contributes nothing; coo_error is set.
  - The 4-cycle timing is unchanged and the remaining edges are still processed.
- Arithmetic:
  - Unsigned, element-wise, modulo 2^DOT_PROD_WIDTH (wrap, no saturation).
  - The graph is undirected: each edge updates both endpoints.
- Latency:
  - done_comb goes high exactly 4*COO_NUM_OF_COLS+2 cycles after the edge where start was sampled (24+2=26 at defaults).
- DONE:
  - done_comb=1 and the matrix is held stable indefinitely. This covers the argmax stage's FEATURE_ROWS-cycle consumption window.
  - start=1 in DONE -> CLEAR: done_comb drops the next cycle and the matrix is zeroed.
- start is ignored in every other state, so there is no restart mid-run.
- fm_wm_row_address and coo_address hold their last values in IDLE and DONE.

Optional Feature:
- Macro: COO_SELF_LOOP_EN.
- Defined:
  - After the last edge, add a SELF state pass: for i=0..FEATURE_ROWS-1, drive fm_wm_row_address=i, then one cycle later do out[i] += fm_wm_row_in.
  - This takes 2 cycles per row (request and accumulate), giving ADJ+I.
  - Latency becomes 4*COO_NUM_OF_COLS+2*FEATURE_ROWS+2 (38 at defaults).
- Undefined: SELF state absent; latency as above.

Test Plan:
- Common setup: FM_WM row i = [i+1, 10(i+1), 100(i+1)].
- Single edge: edges {(0,1), then five (2,2)}.
  - Expect out[0]=[2,20,200] and out[1]=[1,10,100].
  - out[2] = 5 x [3,30,300] = [15,150,1500].
  - Other rows 0; done_comb high at cycle 26.
- Reset mid-run: pull reset low at cycle 10 of a run.
  - Next cycle: matrix all 0, done_comb=0, state IDLE.
  - A subsequent start gives the correct result at 26 cycles.
- Out-of-range: edge (7,0) among 5 valid edges.
  - coo_error=1; row 0 lacks that contribution; done_comb still at cycle 26.
- Wrap: FM_WM row 1 = [0xFFFF,...]; edges (0,1),(0,1).
  - out[0][0] = 0xFFFE.
- Restart from DONE: hold DONE for 10 cycles (matrix stable, done_comb=1), then pulse start with different COO contents.
  - done_comb=0 the next cycle; new result at 26 cycles; no residue from the previous run.
- With COO_SELF_LOOP_EN, single-edge case: out[0] = [1,10,100]+[2,20,200] = [3,30,300]; done_comb at cycle 38.
